// File: rtl/lcd_pkg.sv
// Shared types and constants for the LCD message arbiter.
// The optional feature LCD_MSG_DEDUP_EN is handled in lcd_message_arbiter.sv.
package lcd_pkg;

    // Arbiter sequencing states
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LAUNCH  = 2'd1,
        ST_REFRESH = 2'd2,
        ST_HOLD    = 2'd3
    } state_t;

    // Stored message ids understood by the LCD1602 text controller
    localparam logic [2:0] MSG_IDLE = 3'd0;
    localparam logic [2:0] MSG_1    = 3'd1;
    localparam logic [2:0] MSG_2    = 3'd2;
    localparam logic [2:0] MSG_3    = 3'd3;
    localparam logic [2:0] MSG_4    = 3'd4;
    localparam logic [2:0] MSG_5    = 3'd5;
    localparam logic [2:0] MSG_6    = 3'd6;
    localparam logic [2:0] MSG_7    = 3'd7;

    // Controller's internal tick period; ready must outlast two of its ticks
    localparam int COUNT_MAX         = 800_000;
    localparam int DEF_READY_CYCLES  = 2 * COUNT_MAX;

    // Timer reload for the hold phase; a zero hold still costs one cycle
    function automatic int hold_load(input int hold_cycles);
        return (hold_cycles == 0) ? 0 : hold_cycles - 1;
    endfunction

endpackage

// File: rtl/lcd_rr_pick.sv
// Combinational round-robin search: first asserted request at or after ptr,
// wrapping from NUM_REQ-1 back to 0.
module lcd_rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      ptr,
    output logic [NUM_REQ-1:0] win_oh,
    output logic [IW-1:0]      win_idx,
    output logic               win_vld
);

    int j;

    // Walk the requesters in priority order starting at the pointer
    always_comb begin
        win_oh  = '0;
        win_idx = '0;
        win_vld = 1'b0;
        j       = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = int'(ptr) + k;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            if (!win_vld && req[j]) begin
                win_vld    = 1'b1;
                win_idx    = IW'(j);
                win_oh[j]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/lcd_message_arbiter.sv
// Round-robin arbiter sharing the LCD1602 text controller between requesters.
// Times the ready pulse, the controller refresh and a minimum hold period.
// Optional feature macro: LCD_MSG_DEDUP_EN (skip redraw of an unchanged message).
module lcd_message_arbiter
    import lcd_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int MSG_W          = 3,
    parameter int READY_CYCLES   = DEF_READY_CYCLES,
    parameter int REFRESH_CYCLES = 150_000_000,
    parameter int HOLD_CYCLES    = 50_000_000,
    parameter int IW             = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*MSG_W-1:0] req_msg,
    output logic [NUM_REQ-1:0]       gnt,
    output logic [MSG_W-1:0]         message_select,
    output logic                     ready_o,
    output logic                     busy,
    output logic [IW-1:0]            active_id
);

    localparam int TW = $clog2(REFRESH_CYCLES);
    localparam logic [TW-1:0] READY_LOAD   = TW'(READY_CYCLES - 1);
    localparam logic [TW-1:0] REFRESH_LOAD = TW'(REFRESH_CYCLES - READY_CYCLES - 1);
    localparam logic [TW-1:0] HOLD_LOAD    = TW'(hold_load(HOLD_CYCLES));

    state_t               state_q, state_d;
    logic [TW-1:0]        timer_q, timer_d;
    logic [IW-1:0]        ptr_q, ptr_d;
    logic [NUM_REQ-1:0]   gnt_d;
    logic [MSG_W-1:0]     msg_d;
    logic                 rdy_d, busy_d;
    logic [IW-1:0]        id_d;
    logic                 shown_q, shown_d;

    logic [NUM_REQ-1:0]   pick_oh;
    logic [IW-1:0]        pick_idx;
    logic                 pick_vld;
    logic [MSG_W-1:0]     pick_msg;
    logic                 dedup_hit;

    lcd_rr_pick #(.NUM_REQ(NUM_REQ), .IW(IW)) u_pick (
        .req     (req),
        .ptr     (ptr_q),
        .win_oh  (pick_oh),
        .win_idx (pick_idx),
        .win_vld (pick_vld)
    );

    assign pick_msg = req_msg[pick_idx*MSG_W +: MSG_W];

`ifdef LCD_MSG_DEDUP_EN
    // Same message already on screen after a completed refresh: ack only
    assign dedup_hit = shown_q && (pick_msg == message_select);
`else
    assign dedup_hit = 1'b0;
`endif

    // Next-state and registered-output computation
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        ptr_d   = ptr_q;
        gnt_d   = '0;
        msg_d   = message_select;
        rdy_d   = ready_o;
        busy_d  = busy;
        id_d    = active_id;
        shown_d = shown_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_vld) begin
                    gnt_d = pick_oh;
                    id_d  = pick_idx;
                    ptr_d = (pick_idx == IW'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
                    if (!dedup_hit) begin
                        msg_d   = pick_msg;
                        rdy_d   = 1'b1;
                        busy_d  = 1'b1;
                        timer_d = READY_LOAD;
                        state_d = ST_LAUNCH;
                    end
                end
            end
            ST_LAUNCH: begin
                if (timer_q == '0) begin
                    rdy_d   = 1'b0;
                    timer_d = REFRESH_LOAD;
                    state_d = ST_REFRESH;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            ST_REFRESH: begin
                if (timer_q == '0) begin
                    timer_d = HOLD_LOAD;
                    state_d = ST_HOLD;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            ST_HOLD: begin
                if (timer_q == '0) begin
                    busy_d  = 1'b0;
                    shown_d = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers, cleared asynchronously
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= ST_IDLE;
            timer_q        <= '0;
            ptr_q          <= '0;
            gnt            <= '0;
            message_select <= '0;
            ready_o        <= 1'b0;
            busy           <= 1'b0;
            active_id      <= '0;
            shown_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            timer_q        <= timer_d;
            ptr_q          <= ptr_d;
            gnt            <= gnt_d;
            message_select <= msg_d;
            ready_o        <= rdy_d;
            busy           <= busy_d;
            active_id      <= id_d;
            shown_q        <= shown_d;
        end
    end

endmodule
